// File: rtl/nfc_cmd_sched.sv
// Flash controller command scheduler: round-robin intake from two requesters into an
// in-order command FIFO, issued one at a time to the NFC with completion and timeout.
module nfc_cmd_sched #(
  parameter int unsigned DEPTH = 4,
  parameter logic [15:0] TOUT  = 16'hFFFF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req0_valid,
  input  logic [32:0]            req0_cmd,
  output logic                   req0_ready,
  input  logic                   req1_valid,
  input  logic [32:0]            req1_cmd,
  output logic                   req1_ready,
  output logic [32:0]            nfc_cmd,
  output logic                   nfc_start,
  input  logic                   nfc_done,
  output logic                   cpl_valid,
  output logic                   cpl_id,
  output logic                   cpl_err,
  output logic [$clog2(DEPTH):0] q_count
);
  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned CW    = AW + 1;
  localparam int unsigned CMD_W = 33;
  localparam int unsigned ENT_W = CMD_W + 1;
  localparam int unsigned TW    = 16;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CHECK     = 3'd1,
    START     = 3'd2,
    WAIT_BUSY = 3'd3,
    WAIT_DONE = 3'd4,
    CPL       = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic [ENT_W-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             last_grant, grant;
  logic             not_full, empty, push, pop;
  logic [CMD_W-1:0] push_cmd;
  logic [ENT_W-1:0] head;
  logic             id_q;
  logic [TW-1:0]    tmr_q;
  logic             tmo, err_d;

  // Round-robin grant; a lone requester always wins, a tie goes to the one not served last.
  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid) grant = ~last_grant;
    else if (req1_valid)          grant = 1'b1;
  end

  assign not_full   = (q_count != CW'(DEPTH));
  assign empty      = (q_count == '0);
  assign req0_ready = !rst && not_full && !grant;
  assign req1_ready = !rst && not_full &&  grant;
  assign push       = (req0_valid && req0_ready) || (req1_valid && req1_ready);
  assign push_cmd   = grant ? req1_cmd : req0_cmd;
  assign head       = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {grant, push_cmd};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      q_count    <= '0;
      last_grant <= 1'b1;
    end else begin
      if (push) begin
        wr_ptr     <= AW'(wr_ptr + 1'b1);
        last_grant <= grant;
      end
      if (pop) rd_ptr <= AW'(rd_ptr + 1'b1);
      if (push && !pop)      q_count <= CW'(q_count + 1'b1);
      else if (pop && !push) q_count <= CW'(q_count - 1'b1);
    end
  end

  // Timer counts wait cycles; abort on the cycle it would reach TOUT.
  assign tmo = (({1'b0, tmr_q} + 17'd1) == {1'b0, TOUT});

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty && nfc_done) begin
          pop     = 1'b1;
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (nfc_cmd[6:0] == 7'd0) begin
          err_d   = 1'b1;
          state_d = CPL;
        end else begin
          state_d = START;
        end
      end
      START: state_d = WAIT_BUSY;
      WAIT_BUSY: begin
        if (!nfc_done) begin
          state_d = WAIT_DONE;
        end else if (tmo) begin
          err_d   = 1'b1;
          state_d = CPL;
        end
      end
      WAIT_DONE: begin
        if (nfc_done) begin
          state_d = CPL;
        end else if (tmo) begin
          err_d   = 1'b1;
          state_d = CPL;
        end
      end
      CPL:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Registered launch/completion outputs and the issued-command holding registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      nfc_cmd   <= '0;
      id_q      <= 1'b0;
      nfc_start <= 1'b0;
      cpl_valid <= 1'b0;
      cpl_id    <= 1'b0;
      cpl_err   <= 1'b0;
      tmr_q     <= '0;
    end else begin
      nfc_start <= (state_d == START);
      cpl_valid <= (state_d == CPL);
      if (pop) begin
        nfc_cmd <= head[CMD_W-1:0];
        id_q    <= head[ENT_W-1];
      end
      if (state_d == CPL) begin
        cpl_id  <= id_q;
        cpl_err <= err_d;
      end
      if (state_q == START)
        tmr_q <= '0;
      else if (state_q == WAIT_BUSY || state_q == WAIT_DONE)
        tmr_q <= TW'(tmr_q + 1'b1);
    end
  end

endmodule

// File: tb/tb_nfc_cmd_sched.sv
// Directed bench for nfc_cmd_sched: arbitration/occupancy vector table plus
// sequences for single write, contention, full queue, zero length, timeout and reset.
module tb_nfc_cmd_sched;
  logic        clk, rst;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [32:0] req0_cmd, req1_cmd, nfc_cmd;
  logic        nfc_start, nfc_done, cpl_valid, cpl_id, cpl_err;
  logic [2:0]  q_count;

  logic        t_req0_valid, t_req0_ready, t_req1_valid, t_req1_ready;
  logic [32:0] t_req0_cmd, t_req1_cmd, t_nfc_cmd;
  logic        t_nfc_start, t_nfc_done, t_cpl_valid, t_cpl_id, t_cpl_err;
  logic [2:0]  t_q_count;

  int checks, errors, cyc;
  int busy_len, busy_left;
  logic hold_busy;

  int          acc_id[$];
  logic [32:0] acc_cmd[$];
  int          cpl_ids[$];
  int          cpl_errs[$];
  logic [32:0] start_cmd[$];
  int          n_start, push_cyc, start_cyc, cpl_cyc;

  typedef struct packed {
    logic       rst;
    logic       v0;
    logic       v1;
    logic       r0;
    logic       r1;
    logic [2:0] cnt;
  } vec_t;
  vec_t vecs[11];

  nfc_cmd_sched #(.DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_cmd(req0_cmd), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_cmd(req1_cmd), .req1_ready(req1_ready),
    .nfc_cmd(nfc_cmd), .nfc_start(nfc_start), .nfc_done(nfc_done),
    .cpl_valid(cpl_valid), .cpl_id(cpl_id), .cpl_err(cpl_err), .q_count(q_count)
  );

  nfc_cmd_sched #(.DEPTH(4), .TOUT(16'd10)) u_tmo (
    .clk(clk), .rst(rst),
    .req0_valid(t_req0_valid), .req0_cmd(t_req0_cmd), .req0_ready(t_req0_ready),
    .req1_valid(t_req1_valid), .req1_cmd(t_req1_cmd), .req1_ready(t_req1_ready),
    .nfc_cmd(t_nfc_cmd), .nfc_start(t_nfc_start), .nfc_done(t_nfc_done),
    .cpl_valid(t_cpl_valid), .cpl_id(t_cpl_id), .cpl_err(t_cpl_err), .q_count(t_q_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // NFC model: busy for busy_len cycles after each start, aborted by reset.
  always @(posedge clk) begin
    if (rst)                 busy_left <= 0;
    else if (nfc_start)      busy_left <= busy_len;
    else if (busy_left != 0) busy_left <= busy_left - 1;
  end
  assign nfc_done = !hold_busy && (busy_left == 0);

  always @(negedge clk) begin
    if (req0_valid && req0_ready) begin acc_id.push_back(0); acc_cmd.push_back(req0_cmd); push_cyc = cyc; end
    if (req1_valid && req1_ready) begin acc_id.push_back(1); acc_cmd.push_back(req1_cmd); push_cyc = cyc; end
    if (nfc_start) begin n_start++; start_cmd.push_back(nfc_cmd); start_cyc = cyc; end
    if (cpl_valid) begin cpl_ids.push_back(int'(cpl_id)); cpl_errs.push_back(int'(cpl_err)); cpl_cyc = cyc; end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic clear_logs();
    acc_id.delete(); acc_cmd.delete(); cpl_ids.delete(); cpl_errs.delete(); start_cmd.delete();
    n_start = 0;
  endtask

  task automatic wait_cpl(input int n, input int bound, input string name);
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (cpl_ids.size() >= n) break;
    end
    chk(name, 64'(cpl_ids.size()), 64'(n));
  endtask

  initial begin
    int n0, n1, k, got;
    int t_st[$], t_cp[$], t_er[$];
    logic [32:0] t_sc[$];
    logic [32:0] cmd_a, cmd_b, cmd5;

    clk = 1'b0; rst = 1'b1; cyc = 0; checks = 0; errors = 0;
    busy_len = 3; hold_busy = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_cmd = {1'b1, 18'h00001, 7'h02, 7'd4};
    req1_cmd = {1'b0, 18'h00005, 7'h06, 7'd7};
    t_req0_valid = 1'b0; t_req1_valid = 1'b0; t_req0_cmd = '0; t_req1_cmd = '0;
    t_nfc_done = 1'b1;
    clear_logs();

    // Reset state, readiness gated by rst
    tick(); tick();
    @(negedge clk);
    chk("rst_q_count", 64'(q_count), 64'(0));
    chk("rst_nfc_start", 64'(nfc_start), 64'(0));
    chk("rst_nfc_cmd", 64'(nfc_cmd), 64'(0));
    chk("rst_cpl_valid", 64'(cpl_valid), 64'(0));
    chk("rst_cpl_id", 64'(cpl_id), 64'(0));
    chk("rst_cpl_err", 64'(cpl_err), 64'(0));
    chk("rst_req0_ready", 64'(req0_ready), 64'(0));
    chk("rst_req1_ready", 64'(req1_ready), 64'(0));
    tick();
    rst = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;

    // Arbitration / occupancy table with the NFC held busy (no pops)
    hold_busy = 1'b1;
    vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0};
    vecs[1]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 3'd0};
    vecs[2]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 3'd1};
    vecs[3]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 3'd2};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'd3};
    vecs[5]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd4};
    vecs[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd4};
    vecs[7]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd4};
    vecs[8]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 3'd0};
    vecs[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0};
    for (int i = 0; i < 11; i++) begin
      rst = vecs[i].rst; req0_valid = vecs[i].v0; req1_valid = vecs[i].v1;
      @(negedge clk);
      chk($sformatf("vec%0d_req0_ready", i), 64'(req0_ready), 64'(vecs[i].r0));
      chk($sformatf("vec%0d_req1_ready", i), 64'(req1_ready), 64'(vecs[i].r1));
      chk($sformatf("vec%0d_q_count", i), 64'(q_count), 64'(vecs[i].cnt));
      tick();
    end
    rst = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
    hold_busy = 1'b0;

    // Single write with a 20-cycle busy NFC
    do_reset(); clear_logs(); busy_len = 20;
    cmd_a = {1'b0, 18'h00010, 7'h00, 7'd8};
    req0_valid = 1'b1; req0_cmd = cmd_a;
    @(negedge clk);
    chk("wr_req0_ready", 64'(req0_ready), 64'(1));
    tick(); req0_valid = 1'b0;
    wait_cpl(1, 60, "wr_cpl_count");
    chk("wr_n_start", 64'(n_start), 64'(1));
    chk("wr_start_latency", 64'(start_cyc - push_cyc), 64'(3));
    chk("wr_cpl_latency", 64'(cpl_cyc - start_cyc), 64'(22));
    if (cpl_ids.size() > 0) begin
      chk("wr_cpl_id", 64'(cpl_ids[0]), 64'(0));
      chk("wr_cpl_err", 64'(cpl_errs[0]), 64'(0));
    end
    repeat (3) tick();
    @(negedge clk);
    chk("wr_nfc_cmd_held", 64'(nfc_cmd), 64'(cmd_a));
    tick();

    // Contention: both requesters hold valid for 6 commands each
    do_reset(); clear_logs(); busy_len = 3;
    n0 = 0; n1 = 0;
    for (int i = 0; i < 200 && (n0 < 6 || n1 < 6); i++) begin
      req0_valid = (n0 < 6); req1_valid = (n1 < 6);
      req0_cmd = {1'b1, 18'(i), 7'(i), 7'(n0 + 1)};
      req1_cmd = {1'b0, 18'(i + 100), 7'(i), 7'(n1 + 1)};
      @(negedge clk);
      if (req0_valid && req0_ready) n0++;
      if (req1_valid && req1_ready) n1++;
      tick();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    wait_cpl(12, 300, "cont_cpl_count");
    chk("cont_acc_count", 64'(acc_id.size()), 64'(12));
    chk("cont_start_count", 64'(start_cmd.size()), 64'(12));
    for (int i = 0; i < 12; i++) begin
      if (i < acc_id.size()) chk($sformatf("cont_acc%0d_id", i), 64'(acc_id[i]), 64'(i % 2));
      if (i < cpl_ids.size()) begin
        chk($sformatf("cont_cpl%0d_id", i), 64'(cpl_ids[i]), 64'(i % 2));
        chk($sformatf("cont_cpl%0d_err", i), 64'(cpl_errs[i]), 64'(0));
      end
      if (i < start_cmd.size() && i < acc_cmd.size())
        chk($sformatf("cont_start%0d_cmd", i), 64'(start_cmd[i]), 64'(acc_cmd[i]));
    end

    // Full queue: NFC busy, req0 offers 5 commands
    do_reset(); clear_logs(); hold_busy = 1'b1; busy_len = 2;
    for (int i = 0; i < 4; i++) begin
      req0_valid = 1'b1; req0_cmd = {1'b0, 18'(i + 16), 7'(i), 7'd2};
      @(negedge clk);
      chk($sformatf("full_push%0d_ready", i), 64'(req0_ready), 64'(1));
      tick();
    end
    cmd5 = {1'b0, 18'h3FFFF, 7'h7F, 7'd3};
    req0_cmd = cmd5;
    @(negedge clk);
    chk("full_q_count", 64'(q_count), 64'(4));
    chk("full_req0_ready", 64'(req0_ready), 64'(0));
    tick(); tick();
    hold_busy = 1'b0;
    got = 0;
    for (int i = 0; i < 10 && got == 0; i++) begin
      @(negedge clk);
      if (req0_ready) begin
        got = 1;
        chk("full_after_pop_q_count", 64'(q_count), 64'(3));
      end
      tick();
    end
    chk("full_reaccept", 64'(got), 64'(1));
    req0_valid = 1'b0;
    wait_cpl(5, 150, "full_cpl_count");
    chk("full_acc_count", 64'(acc_id.size()), 64'(5));
    if (acc_cmd.size() == 5) chk("full_fifth_cmd", 64'(acc_cmd[4]), 64'(cmd5));
    for (int i = 0; i < 5; i++)
      if (i < start_cmd.size() && i < acc_cmd.size())
        chk($sformatf("full_start%0d_cmd", i), 64'(start_cmd[i]), 64'(acc_cmd[i]));

    // Zero-length command is rejected without an NFC start
    do_reset(); clear_logs(); busy_len = 3;
    req1_valid = 1'b1; req1_cmd = {1'b1, 18'h2AAAA, 7'h11, 7'd0};
    @(negedge clk);
    chk("zl_req1_ready", 64'(req1_ready), 64'(1));
    tick(); req1_valid = 1'b0;
    repeat (10) tick();
    chk("zl_n_start", 64'(n_start), 64'(0));
    chk("zl_cpl_count", 64'(cpl_ids.size()), 64'(1));
    chk("zl_cpl_latency", 64'(cpl_cyc - push_cyc), 64'(3));
    if (cpl_ids.size() > 0) begin
      chk("zl_cpl_id", 64'(cpl_ids[0]), 64'(1));
      chk("zl_cpl_err", 64'(cpl_errs[0]), 64'(1));
    end

    // Timeout (TOUT=10) with an NFC that never goes busy; next command follows
    do_reset();
    cmd_a = {1'b1, 18'h00003, 7'h01, 7'd5};
    cmd_b = {1'b0, 18'h12345, 7'h22, 7'd9};
    t_req0_valid = 1'b1; t_req0_cmd = cmd_a;
    @(negedge clk);
    chk("tmo_ready_a", 64'(t_req0_ready), 64'(1));
    k = cyc;
    tick();
    t_req0_cmd = cmd_b;
    @(negedge clk);
    chk("tmo_ready_b", 64'(t_req0_ready), 64'(1));
    tick(); t_req0_valid = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (t_nfc_start) begin t_st.push_back(cyc); t_sc.push_back(t_nfc_cmd); end
      if (t_cpl_valid) begin t_cp.push_back(cyc); t_er.push_back(int'(t_cpl_err)); end
    end
    chk("tmo_start_count", 64'(t_st.size()), 64'(2));
    chk("tmo_cpl_count", 64'(t_cp.size()), 64'(2));
    if (t_st.size() == 2 && t_cp.size() == 2) begin
      chk("tmo_start_latency", 64'(t_st[0] - k), 64'(3));
      chk("tmo_abort_latency", 64'(t_cp[0] - t_st[0]), 64'(11));
      chk("tmo_err_a", 64'(t_er[0]), 64'(1));
      chk("tmo_next_issue", 64'(t_st[1] - t_cp[0]), 64'(3));
      chk("tmo_cmd_a", 64'(t_sc[0]), 64'(cmd_a));
      chk("tmo_cmd_b", 64'(t_sc[1]), 64'(cmd_b));
      chk("tmo_err_b", 64'(t_er[1]), 64'(1));
    end

    // Reset in WAIT_DONE with 3 queued drops everything silently
    do_reset(); clear_logs(); busy_len = 30;
    for (int i = 0; i < 4; i++) begin
      req0_valid = 1'b1; req0_cmd = {1'b1, 18'(i + 40), 7'(i), 7'd6};
      @(negedge clk);
      chk($sformatf("rr_push%0d_ready", i), 64'(req0_ready), 64'(1));
      tick();
    end
    req0_valid = 1'b0;
    tick();
    @(negedge clk);
    chk("rr_q_count_before", 64'(q_count), 64'(3));
    chk("rr_n_start_before", 64'(n_start), 64'(1));
    tick();
    rst = 1'b1; req0_valid = 1'b1;
    @(negedge clk);
    chk("rr_ready_in_rst", 64'(req0_ready), 64'(0));
    tick();
    rst = 1'b0; req0_valid = 1'b0;
    @(negedge clk);
    chk("rr_q_count_after", 64'(q_count), 64'(0));
    chk("rr_cpl_valid_after", 64'(cpl_valid), 64'(0));
    chk("rr_nfc_start_after", 64'(nfc_start), 64'(0));
    chk("rr_nfc_cmd_after", 64'(nfc_cmd), 64'(0));
    tick();
    repeat (30) tick();
    chk("rr_no_cpl", 64'(cpl_ids.size()), 64'(0));
    chk("rr_no_new_start", 64'(n_start), 64'(1));
    busy_len = 2;
    req0_valid = 1'b1; req0_cmd = {1'b0, 18'h00077, 7'h05, 7'd1};
    @(negedge clk);
    chk("rr_post_ready", 64'(req0_ready), 64'(1));
    tick(); req0_valid = 1'b0;
    wait_cpl(1, 40, "rr_post_cpl_count");
    chk("rr_post_start_latency", 64'(start_cyc - push_cyc), 64'(3));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
